mpm_bus_arbiter: RTL and testbench
==================================

Name: mpm_bus_arbiter

Overview:
- Owns the code RAM (4-bit words) and the data RAM (1-bit words) of the Post CPU.
- Shares both RAMs between a host port (program loading, tape inspection) and the CPU.
- Sequences each CPU run: launch, monitor, completion. Counts the clock cycles of each run and can abort the CPU.
- Sits between Post_cpu, both RAM instances and the host interface logic.

Parameters:
ADDR_W, 8, address width of both RAMs and of the CPU address ports
CODE_W, 4, code RAM word width
CNT_W, 16, width of run_cycles

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
run_req  in  1  host request to start a program (level)
abort  in  1  host request to kill a running program (level)
host_req  in  1  host RAM access request; held until host_ack
host_we  in  1  1 = write, 0 = read
host_sel  in  1  0 = code RAM, 1 = data RAM
host_add  in  ADDR_W  host address
host_wdata  in  CODE_W  write data; data RAM uses bit 0 only
host_rdata  out  CODE_W  registered read data; data RAM read is zero-extended
host_ack  out  1  one-cycle access-complete pulse
busy  out  1  high while the CPU owns the RAMs
done  out  1  one-cycle pulse when a run ends (normal stop or abort)
run_cycles  out  CNT_W  cycle count of the current or last run
cpu_run  out  1  drives Post_cpu run
cpu_reset  out  1  drives Post_cpu reset (active-high)
cpu_state  in  8  Post_cpu state
cpu_code_add  in  ADDR_W  Post_cpu code address
cpu_data_add  in  ADDR_W  Post_cpu data address
cpu_dout  in  1  Post_cpu write bit
cpu_data_we  in  1  Post_cpu data write enable
cpu_code  out  CODE_W  = code_rdata, always
cpu_din  out  1  = data_rdata, always
code_add  out  ADDR_W  code RAM address
code_we  out  1  code RAM write enable
code_wdata  out  CODE_W  code RAM write data
code_rdata  in  CODE_W  code RAM read data, combinational from code_add
data_add  out  ADDR_W  data RAM address
data_we  out  1  data RAM write enable
data_wdata  out  1  data RAM write data
data_rdata  in  1  data RAM read data, combinational from data_add

Behaviour:
- States are IDLE, H_ACC, H_ACK, LAUNCH, WAIT, RUN, KILL, FIN.
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - host_ack, done, cpu_run and run_cycles go to 0; host_rdata goes to 0.
  - cpu_reset goes to 1; it drops to 0 on the first edge with reset=1.
- IDLE:
  - Host owns the RAM address muxes; both we signals are 0.
  - host_req=1 goes to H_ACC. Host has priority over run_req when both are high.
  - Otherwise run_req=1 goes to LAUNCH.
- H_ACC (1 cycle):
  - RAMs are addressed by host_add; host_sel selects which RAM.
  - For a write, the selected we=1 and wdata=host_wdata (data RAM gets bit 0).
  - For a read, the selected rdata is captured into host_rdata at the end of the cycle. host_rdata holds until the next read.
  - Always goes to H_ACK.
- H_ACK: host_ack=1 for this cycle only. Goes to IDLE. A host_req still high is treated as a new access, so back-to-back accesses take 3 cycles each.
- LAUNCH:
  - cpu_run=1 for this cycle only; busy=1.
  - run_cycles is cleared to 0.
  - RAM muxes switch to the CPU.
  - Goes to WAIT.
- WAIT:
  - busy=1.
  - Goes to RUN when cpu_state!=0.
  - Stays in WAIT while cpu_state==0.
  - abort=1 goes to KILL.
- RUN:
  - busy=1. CPU drives the RAMs: code_add=cpu_code_add, data_add=cpu_data_add, data_we=cpu_data_we, data_wdata=cpu_dout, code_we=0.
  - run_cycles increments every RUN cycle and saturates at all-ones.
  - cpu_state==0 goes to FIN.
  - abort=1 goes to KILL. Abort wins over a simultaneous stop.
- KILL:
  - cpu_reset=1 for one cycle; the CPU returns to stop and IP/DP clear.
  - data_we is forced to 0 in this cycle.
  - Goes to FIN.
- FIN: done=1 for one cycle; busy=0. Goes to IDLE.
- Host and run requests during a CPU run:
  - host_req arriving while busy gets no ack; it stays pending and is served from IDLE.
  - run_req while busy is ignored.
  - run_req still high on return to IDLE relaunches the CPU, unless host_req is also high.
- Muxing rules:
  - RAM muxes select the CPU in LAUNCH, WAIT and RUN only; all other states select the host.
  - In states that do no host write, host-side we=0.
- Decoding: cpu_state is compared as a full 8-bit value against 0.

Test Plan:
1. Host write code[0x00]=0x3, then read code[0x00] -> host_ack pulses 2 cycles after each request edge; host_rdata=0x3.
2. Load code {0x1,0x3,0x7} and clear data[0x01], then pulse run_req -> cpu_run pulses once, busy rises, data[0x01]=1 after the run, done pulses once, run_cycles equals the CPU's cycle count from start to stop.
3. host_req=1 and run_req=1 together in IDLE -> host access completes first (host_ack), then LAUNCH on the following IDLE cycle.
4. Load the infinite loop {0x5,0x0,0x0} and run; assert abort after 50 cycles -> cpu_reset=1 for one cycle, done pulses, busy=0, run_cycles holds its value near 50.
5. Assert host_req mid-run -> no host_ack until after done; the access then completes correctly.
6. Pull reset low during RUN -> next cycle: state IDLE, cpu_reset=1, cpu_run=0, done=0, run_cycles=0, host_ack=0.

Source files
------------

// File: rtl/mpm_bus_arbiter.sv
// rtl/mpm_bus_arbiter.sv - RAM sharing and run sequencing between host port and Post CPU
//
// Purpose: owns the code RAM (CODE_W-bit words) and data RAM (1-bit words).
// It lends both RAMs to a host port between runs and to the Post CPU during
// a run. It also launches, monitors, times and can abort each CPU run.
//
// Ports:
//   clk, reset                 system clock, synchronous active-low reset
//   run_req, abort             host run control (levels)
//   host_req/we/sel/add/wdata  host RAM access request, held until host_ack
//   host_rdata, host_ack       registered read data, one-cycle completion pulse
//   busy, done, run_cycles     run status: CPU owns RAMs, end-of-run pulse, cycle count
//   cpu_run, cpu_reset         Post CPU control (cpu_reset active-high)
//   cpu_state, cpu_*_add,      Post CPU status and RAM-side requests
//   cpu_dout, cpu_data_we
//   cpu_code, cpu_din          RAM read data forwarded to the CPU
//   code_*, data_*             code RAM and data RAM ports (combinational read)
module mpm_bus_arbiter #(
    parameter int ADDR_W = 8,
    parameter int CODE_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_req,
    input  logic              abort,
    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_sel,
    input  logic [ADDR_W-1:0] host_add,
    input  logic [CODE_W-1:0] host_wdata,
    output logic [CODE_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  run_cycles,
    output logic              cpu_run,
    output logic              cpu_reset,
    input  logic [7:0]        cpu_state,
    input  logic [ADDR_W-1:0] cpu_code_add,
    input  logic [ADDR_W-1:0] cpu_data_add,
    input  logic              cpu_dout,
    input  logic              cpu_data_we,
    output logic [CODE_W-1:0] cpu_code,
    output logic              cpu_din,
    output logic [ADDR_W-1:0] code_add,
    output logic              code_we,
    output logic [CODE_W-1:0] code_wdata,
    input  logic [CODE_W-1:0] code_rdata,
    output logic [ADDR_W-1:0] data_add,
    output logic              data_we,
    output logic              data_wdata,
    input  logic              data_rdata
);

    typedef enum logic [2:0] {
        IDLE, H_ACC, H_ACK, LAUNCH, WAIT, RUN, KILL, FIN
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   host_rdata_q, host_rdata_d;
    logic [CNT_W-1:0]    run_cycles_q, run_cycles_d;
    logic                rst_hold_q;
    logic                cpu_owns;
    logic                host_wr;
    logic                kill;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            host_rdata_q <= '0;
            run_cycles_q <= '0;
            rst_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            host_rdata_q <= host_rdata_d;
            run_cycles_q <= run_cycles_d;
            rst_hold_q   <= 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        host_rdata_d = host_rdata_q;
        run_cycles_d = run_cycles_q;
        host_ack     = 1'b0;
        done         = 1'b0;
        cpu_run      = 1'b0;
        busy         = 1'b0;
        kill         = 1'b0;
        cpu_owns     = 1'b0;
        host_wr      = 1'b0;
        case (state_q)
            IDLE: begin
                // Host wins a tie so program loading can't be starved by a held run_req.
                if (host_req)     state_d = H_ACC;
                else if (run_req) state_d = LAUNCH;
            end
            H_ACC: begin
                host_wr = host_we;
                if (!host_we)
                    host_rdata_d = host_sel ? {{(CODE_W-1){1'b0}}, data_rdata} : code_rdata;
                state_d = H_ACK;
            end
            H_ACK: begin
                host_ack = 1'b1;
                state_d  = IDLE;
            end
            LAUNCH: begin
                cpu_run      = 1'b1;
                busy         = 1'b1;
                cpu_owns     = 1'b1;
                run_cycles_d = '0;
                state_d      = WAIT;
            end
            WAIT: begin
                busy     = 1'b1;
                cpu_owns = 1'b1;
                if (abort)                 state_d = KILL;
                else if (cpu_state != 8'd0) state_d = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                cpu_owns = 1'b1;
                if (run_cycles_q != '1)
                    run_cycles_d = run_cycles_q + CNT_W'(1);
                // Abort checked first so a kill request is never lost to a coincident stop.
                if (abort)                  state_d = KILL;
                else if (cpu_state == 8'd0) state_d = FIN;
            end
            KILL: begin
                kill    = 1'b1;
                state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign host_rdata = host_rdata_q;
    assign run_cycles = run_cycles_q;
    assign cpu_reset  = rst_hold_q | kill;
    assign cpu_code   = code_rdata;
    assign cpu_din    = data_rdata;

    // Outside CPU ownership the host drives both address buses; KILL falls here, so a
    // dying CPU can never write the data RAM.
    assign code_add   = cpu_owns ? cpu_code_add : host_add;
    assign data_add   = cpu_owns ? cpu_data_add : host_add;
    assign code_we    = host_wr & ~host_sel;
    assign data_we    = cpu_owns ? cpu_data_we : (host_wr & host_sel);
    assign code_wdata = host_wdata;
    assign data_wdata = cpu_owns ? cpu_dout : host_wdata[0];

endmodule

// File: tb/tb_mpm_bus_arbiter.sv
// tb/tb_mpm_bus_arbiter.sv - self-checking bench for mpm_bus_arbiter
`timescale 1ns/1ps
module tb_mpm_bus_arbiter;
    localparam int AW = 8;
    localparam int CW = 4;
    localparam int NW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0, run_req = 1'b0, abort = 1'b0;
    logic          host_req = 1'b0, host_we = 1'b0, host_sel = 1'b0;
    logic [AW-1:0] host_add = '0;
    logic [CW-1:0] host_wdata = '0;
    logic [CW-1:0] host_rdata;
    logic          host_ack, busy, done, cpu_run, cpu_reset;
    logic [NW-1:0] run_cycles;
    logic [7:0]    cpu_state = 8'd0;
    logic [AW-1:0] cpu_code_add = '0, cpu_data_add = '0;
    logic          cpu_dout = 1'b0, cpu_data_we = 1'b0;
    logic [CW-1:0] cpu_code, code_wdata, code_rdata;
    logic          cpu_din, code_we, data_we, data_wdata, data_rdata;
    logic [AW-1:0] code_add, data_add;

    mpm_bus_arbiter #(.ADDR_W(AW), .CODE_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset), .run_req(run_req), .abort(abort),
        .host_req(host_req), .host_we(host_we), .host_sel(host_sel),
        .host_add(host_add), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_ack(host_ack), .busy(busy), .done(done), .run_cycles(run_cycles),
        .cpu_run(cpu_run), .cpu_reset(cpu_reset), .cpu_state(cpu_state),
        .cpu_code_add(cpu_code_add), .cpu_data_add(cpu_data_add),
        .cpu_dout(cpu_dout), .cpu_data_we(cpu_data_we),
        .cpu_code(cpu_code), .cpu_din(cpu_din),
        .code_add(code_add), .code_we(code_we), .code_wdata(code_wdata),
        .code_rdata(code_rdata), .data_add(data_add), .data_we(data_we),
        .data_wdata(data_wdata), .data_rdata(data_rdata)
    );

    // Bench RAMs with combinational read.
    logic [CW-1:0] code_ram [256];
    logic          data_ram [256];
    assign code_rdata = code_ram[code_add];
    assign data_rdata = data_ram[data_add];
    always @(posedge clk) begin
        if (code_we) code_ram[code_add] <= code_wdata;
        if (data_we) data_ram[data_add] <= data_wdata;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scripted stand-in for the Post CPU: runs fc_len cycles (0 = forever) after cpu_run.
    int       fc_len = 5;
    logic     fc_wr_en = 1'b0;
    logic [7:0] fc_code = 8'h01;
    int       fc_steps = 0;
    logic     fc_run_s = 1'b0, fc_rst_s = 1'b0;

    // Reference model: host access phase (0 none, 1 accessing, 2 acknowledging),
    // run phase (0 none, 1 start pulse, 2 awaiting CPU, 3 CPU running, 4 killing, 5 finished).
    int            m_hph = 0, m_rph = 0;
    logic [NW-1:0] m_cnt = '0;
    logic [CW-1:0] m_rdata = '0;
    logic          m_crst = 1'b1;
    logic          m_valid = 1'b0;
    logic [CW-1:0] m_cmem [256];
    logic          m_dmem [256];

    int n_run = 0, n_done = 0, n_crst = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_valid = 1'b1;
            m_hph = 0; m_rph = 0; m_cnt = '0; m_rdata = '0; m_crst = 1'b1;
        end else begin
            m_crst = 1'b0;
            if (m_rph inside {1, 2, 3} && cpu_data_we) m_dmem[cpu_data_add] = cpu_dout;
            if (m_hph == 1) begin
                if (host_we) begin
                    if (host_sel) m_dmem[host_add] = host_wdata[0];
                    else          m_cmem[host_add] = host_wdata;
                end else begin
                    m_rdata = host_sel ? {3'b000, m_dmem[host_add]} : m_cmem[host_add];
                end
                m_hph = 2;
            end else if (m_hph == 2) begin
                m_hph = 0;
            end else begin
                case (m_rph)
                    0: if (host_req) m_hph = 1; else if (run_req) m_rph = 1;
                    1: begin m_cnt = '0; m_rph = 2; end
                    2: if (abort) m_rph = 4; else if (cpu_state != 0) m_rph = 3;
                    3: begin
                        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
                        if (abort) m_rph = 4; else if (cpu_state == 0) m_rph = 5;
                    end
                    4: m_rph = 5;
                    default: m_rph = 0;
                endcase
            end
        end
        #1;
        if (fc_rst_s) begin
            cpu_state = 8'd0; fc_steps = 0;
        end else if (cpu_state == 8'd0) begin
            if (fc_run_s) begin cpu_state = fc_code; fc_steps = 1; end
        end else if (fc_len != 0 && fc_steps == fc_len) begin
            cpu_state = 8'd0;
        end else begin
            fc_steps++;
        end
        cpu_code_add = fc_steps[7:0];
        cpu_data_add = 8'h01;
        cpu_dout     = 1'b1;
        cpu_data_we  = fc_wr_en && cpu_state != 0 && fc_steps == 2;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic own, hwr;
            own = m_rph inside {1, 2, 3};
            hwr = (m_hph == 1) && host_we;
            chk("busy",       {31'd0, busy},      {31'd0, own});
            chk("host_ack",   {31'd0, host_ack},  {31'd0, m_hph == 2});
            chk("done",       {31'd0, done},      {31'd0, m_rph == 5});
            chk("cpu_run",    {31'd0, cpu_run},   {31'd0, m_rph == 1});
            chk("cpu_reset",  {31'd0, cpu_reset}, {31'd0, m_crst || m_rph == 4});
            chk("run_cycles", {16'd0, run_cycles}, {16'd0, m_cnt});
            chk("host_rdata", {28'd0, host_rdata}, {28'd0, m_rdata});
            chk("code_add",   {24'd0, code_add},  {24'd0, own ? cpu_code_add : host_add});
            chk("data_add",   {24'd0, data_add},  {24'd0, own ? cpu_data_add : host_add});
            chk("code_we",    {31'd0, code_we},   {31'd0, hwr && !host_sel});
            chk("data_we",    {31'd0, data_we},   {31'd0, own ? cpu_data_we : (hwr && host_sel)});
            if (data_we)
                chk("data_wdata", {31'd0, data_wdata}, {31'd0, own ? cpu_dout : host_wdata[0]});
            if (code_we)
                chk("code_wdata", {28'd0, code_wdata}, {28'd0, host_wdata});
            chk("cpu_code",   {28'd0, cpu_code},  {28'd0, code_rdata});
            chk("cpu_din",    {31'd0, cpu_din},   {31'd0, data_rdata});
            n_run  += int'(cpu_run);
            n_done += int'(done);
            n_crst += int'(cpu_reset);
        end
        fc_run_s = cpu_run;
        fc_rst_s = cpu_reset;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic host_acc(input logic sel, input logic we, input logic [7:0] a,
                            input logic [3:0] wd, output int lat);
        host_sel = sel; host_we = we; host_add = a; host_wdata = wd; host_req = 1'b1;
        lat = 0;
        do begin tick(); lat++; end while (!host_ack && lat < 300);
        if (!host_ack) chk("host_ack_timeout", 32'd0, 32'd1);
        host_req = 1'b0;
    endtask

    task automatic launch();
        int n;
        run_req = 1'b1; n = 0;
        do begin tick(); n++; end while (!cpu_run && n < 50);
        if (!cpu_run) chk("cpu_run_timeout", 32'd0, 32'd1);
        run_req = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 500) begin tick(); n++; end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int lat, r0, d0, c0;
        tick(); tick();
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_run_cycles", {16'd0, run_cycles}, 32'd0);
        chk("rst_host_rdata", {28'd0, host_rdata}, 32'd0);
        reset = 1'b1;
        tick();
        chk("cpu_reset_release", {31'd0, cpu_reset}, 32'd0);

        // 1: write then read code[0]
        host_acc(1'b0, 1'b1, 8'h00, 4'h3, lat);
        chk("t1_wr_latency", lat, 32'd2);
        tick();
        host_acc(1'b0, 1'b0, 8'h00, 4'h0, lat);
        chk("t1_rd_latency", lat, 32'd2);
        chk("t1_rdata", {28'd0, host_rdata}, 32'h3);
        tick();

        // 2: load program, clear data[1], run to completion
        host_acc(1'b0, 1'b1, 8'h00, 4'h1, lat); tick();
        host_acc(1'b0, 1'b1, 8'h01, 4'h3, lat); tick();
        host_acc(1'b0, 1'b1, 8'h02, 4'h7, lat); tick();
        host_acc(1'b1, 1'b1, 8'h01, 4'hE, lat); tick();
        host_acc(1'b1, 1'b0, 8'h01, 4'h0, lat);
        chk("t2_data_cleared", {28'd0, host_rdata}, 32'h0);
        tick();
        fc_len = 5; fc_wr_en = 1'b1; fc_code = 8'h80;
        r0 = n_run; d0 = n_done;
        launch();
        wait_done();
        chk("t2_run_cycles", {16'd0, run_cycles}, 32'd5);
        chk("t2_busy_in_fin", {31'd0, busy}, 32'd0);
        tick(); tick();
        chk("t2_run_pulses", n_run - r0, 32'd1);
        chk("t2_done_pulses", n_done - d0, 32'd1);
        host_acc(1'b1, 1'b0, 8'h01, 4'h0, lat);
        chk("t2_data_written", {28'd0, host_rdata}, 32'h1);
        tick();

        // 3: host_req and run_req together
        fc_len = 3; fc_wr_en = 1'b0; fc_code = 8'h04;
        run_req = 1'b1;
        host_acc(1'b0, 1'b0, 8'h01, 4'h0, lat);
        chk("t3_host_first", lat, 32'd2);
        chk("t3_rdata", {28'd0, host_rdata}, 32'h3);
        lat = 0;
        do begin tick(); lat++; end while (!cpu_run && lat < 20);
        run_req = 1'b0;
        chk("t3_launch_latency", lat, 32'd2);
        wait_done();
        chk("t3_run_cycles", {16'd0, run_cycles}, 32'd3);
        tick();

        // 4: infinite loop, abort after 50 cycles
        host_acc(1'b0, 1'b1, 8'h00, 4'h5, lat); tick();
        host_acc(1'b0, 1'b1, 8'h01, 4'h0, lat); tick();
        host_acc(1'b0, 1'b1, 8'h02, 4'h0, lat); tick();
        fc_len = 0; fc_code = 8'h01;
        launch();
        repeat (50) tick();
        c0 = n_crst;
        abort = 1'b1;
        wait_done();
        abort = 1'b0;
        chk("t4_run_cycles", {16'd0, run_cycles}, 32'd49);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_kill_pulse", n_crst - c0, 32'd1);
        tick(); tick();
        chk("t4_cnt_holds", {16'd0, run_cycles}, 32'd49);

        // 5: host request in the middle of a run
        fc_len = 8; fc_code = 8'h10;
        launch();
        tick(); tick();
        d0 = n_done;
        host_acc(1'b0, 1'b0, 8'h00, 4'h0, lat);
        chk("t5_done_before_ack", n_done - d0, 32'd1);
        chk("t5_rdata", {28'd0, host_rdata}, 32'h5);
        tick();

        // 6: reset during RUN
        fc_len = 0; fc_code = 8'h02;
        launch();
        repeat (10) tick();
        reset = 1'b0;
        tick();
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("t6_cpu_run", {31'd0, cpu_run}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_run_cycles", {16'd0, run_cycles}, 32'd0);
        chk("t6_host_ack", {31'd0, host_ack}, 32'd0);
        reset = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
